// File: rtl/fmc_frame_reader.sv
// fmc_frame_reader
//   Reads one timestamped ADC frame (4 timestamp words + samples, 16-bit each)
//   out of the FMC capture BRAM on every rising edge of frame_ready and emits
//   it as a single AXI-Stream packet (tuser on word 0, tlast on the last word).
//
// Ports
//   aclk, aresetn        clock / async active-low reset
//   enable, frame_ready  trigger gating and capture-side frame interrupt level
//   bram_*               read-only BRAM port (one-cycle read latency)
//   m_axis_*             AXI-Stream master
//   busy                 frame in progress
//   frame_cnt, drop_cnt  frames completed (wraps), triggers dropped while busy (saturates)
//
// state | meaning
// IDLE  | waiting for a frame_ready rising edge with enable=1
// READ  | issuing BRAM reads for word 0..FRAME_WORDS-1
// DRAIN | all reads issued, waiting for the tlast beat to handshake
module fmc_frame_reader #(
  parameter int ADDR_WIDTH  = 12,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 36
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  frame_ready,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [1:0]            bram_we,
  output logic [15:0]           bram_din,
  input  logic [15:0]           bram_dout,
  output logic [15:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int PTR_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    fr_q;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    en_q, en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  // tag = {last, first}, travels with each read through the BRAM latency
  logic [1:0]              en_tag_q, en_tag_d;
  logic                    rdv_q, rdv_d;
  logic [1:0]              rd_tag_q, rd_tag_d;
  // output buffer entries = {last, first, data}; buf0 is the head
  logic [17:0]             buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;

  logic                    trigger, pop, push, issue, drop;
  logic [2:0]              occ;
  logic [17:0]             new_word;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    en_tag_d    = en_tag_q;
    rdv_d       = en_q;
    rd_tag_d    = en_tag_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    drop        = 1'b0;

    trigger  = frame_ready & ~fr_q & enable;
    pop      = (cnt_q != 2'd0) & m_axis_tready;
    push     = rdv_q;
    new_word = {rd_tag_q, bram_dout};

    // Reads already in the BRAM pipeline are counted against buffer space so
    // the 2-entry buffer can never be overrun even if the stream stalls.
    occ   = 3'(cnt_q) + 3'(en_q) + 3'(rdv_q);
    issue = (state_q == READ) && (occ < (3'd2 + 3'(pop)));

    if (issue) begin
      en_d     = 1'b1;
      addr_d   = BASE + ADDR_WIDTH'(rd_ptr_q);
      en_tag_d = {rd_ptr_q == LAST_PTR, rd_ptr_q == '0};
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      if (cnt_q == 2'd0) buf0_d = new_word;
      else               buf1_d = new_word;
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end else if (push && pop) begin
      if (cnt_q == 2'd1) begin
        buf0_d = new_word;
      end else begin
        buf0_d = buf1_q;
        buf1_d = new_word;
      end
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = READ;
          rd_ptr_d = '0;
        end
      end
      READ: begin
        drop = trigger;
        if (issue && rd_ptr_q == LAST_PTR) state_d = DRAIN;
      end
      DRAIN: begin
        drop = trigger;
        if (pop && buf0_q[17]) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      fr_q        <= 1'b1;
      rd_ptr_q    <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      en_tag_q    <= '0;
      rdv_q       <= 1'b0;
      rd_tag_q    <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fr_q        <= frame_ready;
      rd_ptr_q    <= rd_ptr_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      en_tag_q    <= en_tag_d;
      rdv_q       <= rdv_d;
      rd_tag_q    <= rd_tag_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bram_clk      = aclk;
  assign bram_rst      = ~aresetn;
  assign bram_addr     = addr_q;
  assign bram_en       = en_q;
  assign bram_we       = 2'b00;
  assign bram_din      = 16'h0000;
  assign m_axis_tdata  = buf0_q[15:0];
  assign m_axis_tuser  = buf0_q[16];
  assign m_axis_tlast  = buf0_q[17];
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign busy          = (state_q != IDLE);
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule
